// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared types and opcode constants for the ID hazard controller
package id_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  // Redirect down-counter is sized for the largest legal FLUSH_CYCLES (15)
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [2:0] {
    IMM_TYPE_I,
    IMM_TYPE_S,
    IMM_TYPE_B,
    IMM_TYPE_U,
    IMM_TYPE_J,
    IMM_TYPE_R
  } imm_sel_e;

  typedef enum logic {
    HZ_RUN,
    HZ_REDIRECT
  } hz_state_e;

endpackage

// File: rtl/id_hazard_ctrl_imm_type_decode.sv
// rtl/id_hazard_ctrl_imm_type_decode.sv - opcode to immediate type, register usage and legality
module imm_type_decode
  import id_hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_sel_e   imm_sel_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o,
  output logic       illegal_o
);

  always_comb begin
    imm_sel_o  = IMM_TYPE_R;
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_sel_o = IMM_TYPE_I;
      OPC_STORE: begin
        imm_sel_o  = IMM_TYPE_S;
        rs2_used_o = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_o  = IMM_TYPE_B;
        rs2_used_o = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_o  = IMM_TYPE_U;
        rs1_used_o = 1'b0;
      end
      OPC_JAL: begin
        imm_sel_o  = IMM_TYPE_J;
        rs1_used_o = 1'b0;
      end
      OPC_OP:                  rs2_used_o = 1'b1;
      OPC_SYSTEM, OPC_MISCMEM: ;
      default:                 illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID stage load-use stall, redirect flush sequencing and perf counters
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_i,
  input  logic                 id_valid_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_read_i,
  input  logic [4:0]           ex_rd_i,
  input  logic                 branch_taken_i,
  input  logic                 ex_busy_i,
  output imm_sel_e             ImmSel_o,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 flush_id_o,
  output logic                 bubble_ex_o,
  output logic                 illegal_instr_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] RELOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX = '1;

  logic       rs1_used, rs2_used, opc_illegal, hz;
  logic [4:0] rs1, rs2;
  logic       unused_instr_bits;

  hz_state_e                state_q, state_d;
  logic [FLUSH_CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]     flush_cnt_q, flush_cnt_d;
  logic                     stall, flush, bubble;

  imm_type_decode u_decode (
    .opcode_i   (instr_i[6:0]),
    .imm_sel_o  (ImmSel_o),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .illegal_o  (opc_illegal)
  );

  assign rs1               = instr_i[19:15];
  assign rs2               = instr_i[24:20];
  assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:7]};
  assign illegal_instr_o   = id_valid_i & opc_illegal;

  assign hz = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
              ((rs1_used & (rs1 == ex_rd_i)) | (rs2_used & (rs2 == ex_rd_i)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall       = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    if (branch_taken_i) begin
      flush  = 1'b1;
      bubble = 1'b1;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      if (FLUSH_CYCLES > 1) begin
        state_d = HZ_REDIRECT;
        fcnt_d  = RELOAD;
      end
    end else if (state_q == HZ_REDIRECT) begin
      flush  = 1'b1;
      bubble = 1'b1;
      fcnt_d = fcnt_q - 1'b1;
      if (fcnt_q == FLUSH_CNT_W'(1)) state_d = HZ_RUN;
    end else if (ex_busy_i) begin
      // EX keeps its own in-flight op, so no bubble is injected
      stall = 1'b1;
    end else if (hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Control outputs are combinational, so reset must mask them directly
  assign stall_if_o  = rst_n & stall;
  assign stall_id_o  = rst_n & stall;
  assign flush_id_o  = rst_n & flush;
  assign bubble_ex_o = rst_n & bubble;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - bench for id_hazard_ctrl against a cycle-level reference model
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        id_valid, ex_valid, ex_mem_read, branch_taken, ex_busy;
  logic [4:0]  ex_rd;

  imm_sel_e    imm0, imm1;
  logic        sif0, sid0, fl0, bub0, ill0;
  logic        sif1, sid1, fl1, bub1, ill1;
  logic [3:0]  sc0, fc0;
  logic [31:0] sc1, fc1;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .id_valid_i(id_valid),
    .ex_valid_i(ex_valid), .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
    .branch_taken_i(branch_taken), .ex_busy_i(ex_busy), .ImmSel_o(imm0),
    .stall_if_o(sif0), .stall_id_o(sid0), .flush_id_o(fl0), .bubble_ex_o(bub0),
    .illegal_instr_o(ill0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  id_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .id_valid_i(id_valid),
    .ex_valid_i(ex_valid), .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
    .branch_taken_i(branch_taken), .ex_busy_i(ex_busy), .ImmSel_o(imm1),
    .stall_if_o(sif1), .stall_id_o(sid1), .flush_id_o(fl1), .bubble_ex_o(bub1),
    .illegal_instr_o(ill1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  int     checks = 0;
  int     failures = 0;
  int     flush_left [2];
  longint scnt [2];
  longint fcnt [2];
  int     flen [2] = '{2, 3};
  longint cmax [2] = '{64'd15, 64'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_imm(input logic [6:0] opc);
    if (opc == OPC_LOAD || opc == OPC_OPIMM || opc == OPC_JALR) return IMM_TYPE_I;
    if (opc == OPC_STORE)                  return IMM_TYPE_S;
    if (opc == OPC_BRANCH)                 return IMM_TYPE_B;
    if (opc == OPC_LUI || opc == OPC_AUIPC) return IMM_TYPE_U;
    if (opc == OPC_JAL)                    return IMM_TYPE_J;
    return IMM_TYPE_R;
  endfunction

  function automatic bit ref_known(input logic [6:0] opc);
    logic [6:0] legal [11] = '{OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
                               OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_SYSTEM, OPC_MISCMEM};
    foreach (legal[i]) if (legal[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ref_hz();
    logic [6:0] opc = instr[6:0];
    bit use1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    bit use2 = (opc == OPC_STORE || opc == OPC_BRANCH || opc == OPC_OP);
    if (!(id_valid && ex_valid && ex_mem_read && ex_rd != 5'd0)) return 1'b0;
    return (use1 && instr[19:15] == ex_rd) || (use2 && instr[24:20] == ex_rd);
  endfunction

  task automatic drive(input logic [31:0] ins, input bit idv, input bit exv, input bit exmr,
                       input logic [4:0] exrd, input bit br, input bit busy);
    instr = ins; id_valid = idv; ex_valid = exv; ex_mem_read = exmr;
    ex_rd = exrd; branch_taken = br; ex_busy = busy;
  endtask

  // Expected {stall_if, stall_id, flush_id, bubble_ex} and next model state per instance
  task automatic check_outputs(input string tag, input bit advance);
    logic [3:0] exp_ctl, obs_ctl;
    bit hz = ref_hz();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        flush_left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
      if (!rst_n)                  exp_ctl = 4'b0000;
      else if (branch_taken)       exp_ctl = 4'b0011;
      else if (flush_left[k] > 0)  exp_ctl = 4'b0011;
      else if (ex_busy)            exp_ctl = 4'b1100;
      else if (hz)                 exp_ctl = 4'b1101;
      else                         exp_ctl = 4'b0000;
      obs_ctl = (k == 0) ? {sif0, sid0, fl0, bub0} : {sif1, sid1, fl1, bub1};
      chk($sformatf("%s.d%0d.ctl", tag, k), 64'(obs_ctl), 64'(exp_ctl));
      chk($sformatf("%s.d%0d.stall_cnt", tag, k), (k == 0) ? 64'(sc0) : 64'(sc1), scnt[k]);
      chk($sformatf("%s.d%0d.flush_cnt", tag, k), (k == 0) ? 64'(fc0) : 64'(fc1), fcnt[k]);
      chk($sformatf("%s.d%0d.imm", tag, k), (k == 0) ? 64'(imm0) : 64'(imm1),
          64'(ref_imm(instr[6:0])));
      chk($sformatf("%s.d%0d.illegal", tag, k), (k == 0) ? 64'(ill0) : 64'(ill1),
          64'(id_valid && !ref_known(instr[6:0])));
      if (advance && rst_n) begin
        if (branch_taken) begin
          if (fcnt[k] < cmax[k]) fcnt[k]++;
          flush_left[k] = flen[k] - 1;
        end else if (flush_left[k] > 0) begin
          flush_left[k]--;
        end else if (!ex_busy && hz) begin
          if (scnt[k] < cmax[k]) scnt[k]++;
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    #3;
    check_outputs(tag, 1'b1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_X6_X5_X1 = 32'h0012_8333;
  localparam logic [31:0] LUI_X5       = 32'h0002_82B7;

  initial begin
    logic [6:0] opcs [12] = '{OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI,
                              OPC_AUIPC, OPC_JAL, OPC_OP, OPC_SYSTEM, OPC_MISCMEM, 7'h7F};
    rst_n = 1'b0;
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 1, 0);
    #2;
    check_outputs("reset", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'h0, 0, 0, 0, 5'd0, 0, 0);
    cycle("idle");

    drive(32'h0051_2023, 1, 0, 0, 5'd0, 0, 0);
    #1 chk("imm_sw", 64'(imm0), 64'(IMM_TYPE_S));
    cycle("dec_sw");
    drive(32'h0000_10B7, 1, 0, 0, 5'd0, 0, 0);
    #1 chk("imm_lui", 64'(imm0), 64'(IMM_TYPE_U));
    cycle("dec_lui");
    drive(32'h0000_006F, 1, 0, 0, 5'd0, 0, 0);
    #1 chk("imm_jal", 64'(imm1), 64'(IMM_TYPE_J));
    cycle("dec_jal");
    drive(32'h0000_007F, 1, 0, 0, 5'd0, 0, 0);
    #1 chk("illegal_7f", 64'({ill0, imm0}), 64'({1'b1, IMM_TYPE_R}));
    cycle("dec_illegal");

    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 0);
    cycle("lu_stall");
    drive(ADD_X6_X5_X1, 1, 0, 0, 5'd0, 0, 0);
    cycle("lu_bubble_in_ex");
    chk("lu_stall_cnt", 64'(sc1), 64'd1);
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd0, 0, 0);
    cycle("lu_rd0");
    drive(LUI_X5, 1, 1, 1, 5'd5, 0, 0);
    cycle("lu_lui");

    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 1, 0);
    cycle("br1");
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 0);
    for (int i = 0; i < 3; i++) cycle($sformatf("br1_tail%0d", i));
    chk("br1_flush_cnt", 64'(fc0), 64'd1);
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 1, 0);
    cycle("br2");
    cycle("br2_again");
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 0);
    for (int i = 0; i < 3; i++) cycle($sformatf("br2_tail%0d", i));

    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 1);
    cycle("busy_hz");
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 1, 1);
    cycle("br_busy");
    for (int i = 0; i < 3; i++) cycle($sformatf("br_busy_tail%0d", i));

    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 0);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i));
    chk("sat_stall_cnt4", 64'(sc0), 64'd15);

    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 1, 0);
    cycle("rst_br");
    drive(ADD_X6_X5_X1, 1, 1, 1, 5'd5, 0, 0);
    #1 rst_n = 1'b0;
    #1 check_outputs("rst_mid", 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("post_rst");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive(ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
